// File: rtl/env_vca.sv
// ADSR envelope generator driving a signed VCA multiply with a fixed two-cycle output latency.
// Build option ENV_VCA_SAT_EN: saturate the scaled sample to OUT_W bits instead of wrapping.
module env_vca #(
    parameter int OUT_W = 12
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    ena,
    input  logic                    gate,
    input  logic signed [17:0]      In,
    input  logic        [16:0]      atk,
    input  logic        [16:0]      dec,
    input  logic        [16:0]      sus,
    input  logic        [16:0]      rel,
    output logic signed [OUT_W-1:0] Out,
    output logic                    valid,
    output logic        [16:0]      env,
    output logic                    busy
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ATTACK  = 3'd1,
        DECAY   = 3'd2,
        SUSTAIN = 3'd3,
        RELEASE = 3'd4
    } state_t;

    localparam logic [16:0] ENV_MAX = 17'h1FFFF;
    localparam int LIM = 2 ** (OUT_W - 1) - 1;
    localparam logic signed [17:0] POS_LIM = 18'(LIM);
    localparam logic signed [17:0] NEG_LIM = -POS_LIM;

    state_t                    state_q, state_d;
    logic        [16:0]        env_q, env_d;
    logic signed [17:0]        in_reg_q, in_reg_d;
    logic        [16:0]        env_snap_q, env_snap_d;
    logic signed [35:0]        prod_q, prod_d;
    logic signed [OUT_W-1:0]   out_q, out_d;
    logic                      s1_q, s1_d;
    logic                      s2_q, s2_d;
    logic                      valid_q, valid_d;

    logic [17:0]               sum_atk, diff_dec, diff_rel;
    logic signed [17:0]        scaled;
    logic signed [OUT_W-1:0]   reduced;
    logic                      unused_bits;

    // State register and all sequential storage
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            env_q      <= '0;
            in_reg_q   <= '0;
            env_snap_q <= '0;
            prod_q     <= '0;
            out_q      <= '0;
            s1_q       <= 1'b0;
            s2_q       <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            env_q      <= env_d;
            in_reg_q   <= in_reg_d;
            env_snap_q <= env_snap_d;
            prod_q     <= prod_d;
            out_q      <= out_d;
            s1_q       <= s1_d;
            s2_q       <= s2_d;
            valid_q    <= valid_d;
        end
    end

    // Next state and envelope level; a gate change only moves state, env waits for the next ena
    always_comb begin
        state_d  = state_q;
        env_d    = env_q;
        sum_atk  = {1'b0, env_q} + {1'b0, atk};
        diff_dec = {1'b0, env_q} - {1'b0, dec};
        diff_rel = {1'b0, env_q} - {1'b0, rel};
        if (ena) begin
            case (state_q)
                IDLE: begin
                    if (gate) state_d = ATTACK;
                end
                ATTACK: begin
                    if (!gate) begin
                        state_d = RELEASE;
                    end else if (sum_atk >= {1'b0, ENV_MAX}) begin
                        env_d   = ENV_MAX;
                        state_d = DECAY;
                    end else begin
                        env_d = sum_atk[16:0];
                    end
                end
                DECAY: begin
                    if (!gate) begin
                        state_d = RELEASE;
                    end else if (diff_dec[17] || (diff_dec[16:0] <= sus)) begin
                        env_d   = sus;
                        state_d = SUSTAIN;
                    end else begin
                        env_d = diff_dec[16:0];
                    end
                end
                SUSTAIN: begin
                    if (!gate) state_d = RELEASE;
                    else       env_d   = sus;
                end
                RELEASE: begin
                    if (gate) begin
                        state_d = ATTACK;
                    end else if (diff_rel[17] || (diff_rel[16:0] == 17'd0)) begin
                        env_d   = '0;
                        state_d = IDLE;
                    end else begin
                        env_d = diff_rel[16:0];
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Arithmetic shift by 17 keeps product bits 34:17
    assign scaled = prod_q[34:17];

`ifdef ENV_VCA_SAT_EN
    always_comb begin
        if (scaled > POS_LIM)      reduced = POS_LIM[OUT_W-1:0];
        else if (scaled < NEG_LIM) reduced = NEG_LIM[OUT_W-1:0];
        else                       reduced = scaled[OUT_W-1:0];
    end
`else
    assign reduced = scaled[OUT_W-1:0];
`endif

    assign unused_bits = ^{prod_q[35], prod_q[16:0], scaled};

    // Pipeline: a fresh ena cancels whatever is still in flight
    always_comb begin
        in_reg_d   = ena ? In : in_reg_q;
        env_snap_d = ena ? env_q : env_snap_q;
        s1_d       = ena;
        prod_d     = s1_q ? (in_reg_q * $signed({1'b0, env_snap_q})) : prod_q;
        s2_d       = s1_q & ~ena;
        valid_d    = s2_q & ~ena;
        out_d      = (s2_q & ~ena) ? reduced : out_q;
    end

    // Output process
    always_comb begin
        busy  = (state_q != IDLE);
        valid = valid_q;
        Out   = out_q;
        env   = env_q;
    end

endmodule

// File: tb/tb_env_vca.sv
// Bench for env_vca: directed vector tables, hand sequences and a randomized run against an envelope/VCA model.
module tb_env_vca;
  localparam int OUT_W = 12;
  localparam int ENV_MAX = 131071;
  localparam int LIM = 2 ** (OUT_W - 1) - 1;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic              ena = 1'b0;
  logic              gate = 1'b0;
  logic [17:0]       in_v = '0;
  logic [16:0]       atk = '0, dec = '0, sus = '0, rel = '0;
  logic [OUT_W-1:0]  out_w;
  logic              valid_w;
  logic [16:0]       env_w;
  logic              busy_w;

  env_vca #(.OUT_W(OUT_W)) dut (
    .clk(clk), .rst(rst), .ena(ena), .gate(gate), .In(in_v),
    .atk(atk), .dec(dec), .sus(sus), .rel(rel),
    .Out(out_w), .valid(valid_w), .env(env_w), .busy(busy_w)
  );

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // reference model
  localparam int M_IDLE = 0, M_ATK = 1, M_DEC = 2, M_SUS = 3, M_REL = 4;
  int               m_state = M_IDLE;
  int               m_env = 0;
  logic [OUT_W-1:0] m_out = '0;
  logic             m_valid = 1'b0;
  int               cyc = 0;
  logic [OUT_W-1:0] exp_q[$];
  int               due_q[$];

  function automatic logic [OUT_W-1:0] ref_out(input int x, input int e);
    longint p;
    longint sc;
    p = longint'(x) * longint'(e);
    sc = p >>> 17;
`ifdef ENV_VCA_SAT_EN
    if (sc > LIM) sc = LIM;
    if (sc < -LIM) sc = -LIM;
`endif
    return sc[OUT_W-1:0];
  endfunction

  task automatic model_reset();
    m_state = M_IDLE;
    m_env = 0;
    m_out = '0;
    m_valid = 1'b0;
    exp_q.delete();
    due_q.delete();
  endtask

  task automatic model_edge();
    int prev;
    int t;
    if (ena) begin
      prev = m_env;
      if (gate && (m_state == M_IDLE || m_state == M_REL)) m_state = M_ATK;
      else if (!gate && (m_state == M_ATK || m_state == M_DEC || m_state == M_SUS)) m_state = M_REL;
      else begin
        case (m_state)
          M_ATK: begin
            t = m_env + int'(atk);
            if (t >= ENV_MAX) begin m_env = ENV_MAX; m_state = M_DEC; end
            else m_env = t;
          end
          M_DEC: begin
            t = m_env - int'(dec);
            if (t <= int'(sus)) begin m_env = int'(sus); m_state = M_SUS; end
            else m_env = t;
          end
          M_SUS: m_env = int'(sus);
          M_REL: begin
            t = m_env - int'(rel);
            if (t <= 0) begin m_env = 0; m_state = M_IDLE; end
            else m_env = t;
          end
          default: ;
        endcase
      end
      exp_q.delete();
      due_q.delete();
      exp_q.push_back(ref_out(int'($signed(in_v)), prev));
      due_q.push_back(cyc + 2);
    end
    m_valid = 1'b0;
    if (due_q.size() > 0 && due_q[0] == cyc) begin
      m_valid = 1'b1;
      m_out = exp_q.pop_front();
      void'(due_q.pop_front());
    end
  endtask

  // driver tasks
  task automatic step(input logic e, input logic g, input logic [17:0] i,
                      input logic [16:0] a, input logic [16:0] d,
                      input logic [16:0] s, input logic [16:0] r);
    @(negedge clk);
    ena = e; gate = g; in_v = i; atk = a; dec = d; sus = s; rel = r;
    @(posedge clk);
    cyc++;
    model_edge();
    #1;
    chk("valid", 32'(valid_w), 32'(m_valid));
    chk("out", 32'(out_w), 32'(m_out));
    chk("env", 32'(env_w), 32'(m_env));
    chk("busy", 32'(busy_w), 32'(m_state != M_IDLE));
  endtask

  task automatic do_reset();
    @(negedge clk);
    ena = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("rst_env", 32'(env_w), 32'h0);
    chk("rst_busy", 32'(busy_w), 32'h0);
    chk("rst_valid", 32'(valid_w), 32'h0);
    chk("rst_out", 32'(out_w), 32'h0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  // vector table
  typedef struct {
    logic             e;
    logic             g;
    logic [17:0]      i;
    logic [16:0]      a, d, s, r;
    logic [16:0]      x_env;
    logic             x_busy;
    logic             chk_out;
    logic [OUT_W-1:0] x_out;
  } vec_t;
  vec_t tbl[$];

  function automatic void add(input logic e, input logic g, input logic [17:0] i,
                              input logic [16:0] a, input logic [16:0] d,
                              input logic [16:0] s, input logic [16:0] r,
                              input logic [16:0] x_env, input logic x_busy,
                              input logic chk_out, input logic [OUT_W-1:0] x_out);
    vec_t v;
    v.e = e; v.g = g; v.i = i; v.a = a; v.d = d; v.s = s; v.r = r;
    v.x_env = x_env; v.x_busy = x_busy; v.chk_out = chk_out; v.x_out = x_out;
    tbl.push_back(v);
  endfunction

  // ena followed by n idle cycles holding the same env
  function automatic void add_ena(input int n, input logic g, input logic [17:0] i,
                                  input logic [16:0] a, input logic [16:0] d,
                                  input logic [16:0] s, input logic [16:0] r,
                                  input logic [16:0] x_env, input logic x_busy);
    add(1'b1, g, i, a, d, s, r, x_env, x_busy, 1'b0, '0);
    for (int k = 0; k < n; k++) add(1'b0, g, i, a, d, s, r, x_env, x_busy, 1'b0, '0);
  endfunction

  task automatic run_range(input int lo, input int hi);
    for (int k = lo; k <= hi; k++) begin
      step(tbl[k].e, tbl[k].g, tbl[k].i, tbl[k].a, tbl[k].d, tbl[k].s, tbl[k].r);
      chk($sformatf("tbl%0d_env", k), 32'(env_w), 32'(tbl[k].x_env));
      chk($sformatf("tbl%0d_busy", k), 32'(busy_w), 32'(tbl[k].x_busy));
      if (tbl[k].chk_out) chk($sformatf("tbl%0d_out", k), 32'(out_w), 32'(tbl[k].x_out));
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  logic [OUT_W-1:0] ovf_out;
  logic [17:0]      neg2000;
  logic [OUT_W-1:0] neg2000_out;
  int a_end, d_end;

  initial begin
`ifdef ENV_VCA_SAT_EN
    ovf_out = 12'h7FF;
`else
    ovf_out = 12'hFFE;
`endif
    neg2000 = 18'h3F830;
    neg2000_out = 12'h830;

    // attack scenario: ena every 4 cycles
    add_ena(3, 1'b1, 18'd1000, 17'h10000, 17'h0, 17'h0, 17'h0, 17'h00000, 1'b1);
    add_ena(3, 1'b1, 18'd1000, 17'h10000, 17'h0, 17'h0, 17'h0, 17'h10000, 1'b1);
    add_ena(3, 1'b1, 18'd1000, 17'h10000, 17'h0, 17'h0, 17'h0, 17'h1FFFF, 1'b1);
    add_ena(1, 1'b1, 18'd1000, 17'h10000, 17'h0, 17'h0, 17'h0, 17'h1FFFF, 1'b1);
    add(1'b0, 1'b1, 18'd1000, 17'h10000, 17'h0, 17'h0, 17'h0, 17'h1FFFF, 1'b1, 1'b1, 12'd999);
    add(1'b0, 1'b1, 18'd1000, 17'h10000, 17'h0, 17'h0, 17'h0, 17'h1FFFF, 1'b1, 1'b1, 12'd999);
    a_end = tbl.size() - 1;
    // decay, sustain tracking, release
    add_ena(2, 1'b1, 18'd200, 17'h0, 17'h04000, 17'h10000, 17'h0, 17'h1BFFF, 1'b1);
    add_ena(2, 1'b1, 18'd200, 17'h0, 17'h04000, 17'h10000, 17'h0, 17'h17FFF, 1'b1);
    add_ena(2, 1'b1, 18'd200, 17'h0, 17'h04000, 17'h10000, 17'h0, 17'h13FFF, 1'b1);
    add_ena(2, 1'b1, 18'd200, 17'h0, 17'h04000, 17'h10000, 17'h0, 17'h10000, 1'b1);
    add_ena(2, 1'b1, 18'd200, 17'h0, 17'h04000, 17'h08000, 17'h0, 17'h08000, 1'b1);
    add_ena(2, 1'b1, 18'd200, 17'h0, 17'h04000, 17'h10000, 17'h0, 17'h10000, 1'b1);
    add_ena(2, 1'b0, 18'd200, 17'h0, 17'h04000, 17'h10000, 17'h0C000, 17'h10000, 1'b1);
    add_ena(2, 1'b0, 18'd200, 17'h0, 17'h04000, 17'h10000, 17'h0C000, 17'h04000, 1'b1);
    add_ena(2, 1'b0, 18'd200, 17'h0, 17'h04000, 17'h10000, 17'h0C000, 17'h00000, 1'b0);
    d_end = tbl.size() - 1;

    model_reset();
    #12;
    chk("por_env", 32'(env_w), 32'h0);
    chk("por_busy", 32'(busy_w), 32'h0);
    chk("por_valid", 32'(valid_w), 32'h0);
    chk("por_out", 32'(out_w), 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // reset in the middle of attack with a sample in flight
    step(1'b1, 1'b1, 18'd500, 17'h08000, 17'h0, 17'h0, 17'h0);
    step(1'b0, 1'b1, 18'd500, 17'h08000, 17'h0, 17'h0, 17'h0);
    step(1'b0, 1'b1, 18'd500, 17'h08000, 17'h0, 17'h0, 17'h0);
    step(1'b1, 1'b1, 18'd500, 17'h08000, 17'h0, 17'h0, 17'h0);
    chk("mid_atk_env", 32'(env_w), 32'h08000);
    do_reset();
    for (int k = 0; k < 4; k++) begin
      step(1'b0, 1'b1, 18'd500, 17'h08000, 17'h0, 17'h0, 17'h0);
      chk("post_rst_no_valid", 32'(valid_w), 32'h0);
      chk("post_rst_env", 32'(env_w), 32'h0);
    end

    run_range(0, a_end);

    // overflow at full scale input and full envelope
    step(1'b1, 1'b1, 18'h1FFFF, 17'h0, 17'h0, 17'h0, 17'h0);
    step(1'b0, 1'b1, 18'h1FFFF, 17'h0, 17'h0, 17'h0, 17'h0);
    chk("ovf_early", 32'(valid_w), 32'h0);
    step(1'b0, 1'b1, 18'h1FFFF, 17'h0, 17'h0, 17'h0, 17'h0);
    chk("ovf_valid", 32'(valid_w), 32'h1);
    chk("ovf_out", 32'(out_w), 32'(ovf_out));

    run_range(a_end + 1, d_end);

    // two ena pulses one cycle apart at full envelope
    step(1'b1, 1'b1, 18'd0, 17'h1FFFF, 17'h0, 17'h0, 17'h0);
    step(1'b0, 1'b1, 18'd0, 17'h1FFFF, 17'h0, 17'h0, 17'h0);
    step(1'b0, 1'b1, 18'd0, 17'h1FFFF, 17'h0, 17'h0, 17'h0);
    step(1'b1, 1'b1, 18'd0, 17'h1FFFF, 17'h0, 17'h0, 17'h0);
    chk("full_env", 32'(env_w), 32'h1FFFF);
    step(1'b0, 1'b1, 18'd0, 17'h1FFFF, 17'h0, 17'h0, 17'h0);
    step(1'b0, 1'b1, 18'd0, 17'h1FFFF, 17'h0, 17'h0, 17'h0);
    step(1'b1, 1'b1, 18'd1000, 17'h0, 17'h0, 17'h0, 17'h0);
    step(1'b1, 1'b1, neg2000, 17'h0, 17'h0, 17'h0, 17'h0);
    chk("dbl_v0", 32'(valid_w), 32'h0);
    step(1'b0, 1'b1, 18'd0, 17'h0, 17'h0, 17'h0, 17'h0);
    chk("dbl_v1", 32'(valid_w), 32'h0);
    step(1'b0, 1'b1, 18'd0, 17'h0, 17'h0, 17'h0, 17'h0);
    chk("dbl_v2", 32'(valid_w), 32'h1);
    chk("dbl_out", 32'(out_w), 32'(neg2000_out));
    step(1'b0, 1'b1, 18'd0, 17'h0, 17'h0, 17'h0, 17'h0);
    chk("dbl_v3", 32'(valid_w), 32'h0);

    // randomized run
    begin
      logic g;
      logic [16:0] rt[4];
      g = 1'b1;
      for (int n = 0; n < 1500; n++) begin
        if ($urandom_range(0, 15) == 0) g = ~g;
        for (int k = 0; k < 4; k++) begin
          case ($urandom_range(0, 4))
            0: rt[k] = 17'h0;
            1: rt[k] = 17'($urandom_range(1, 255));
            2: rt[k] = 17'($urandom_range(256, 17'h3FFF));
            3: rt[k] = 17'($urandom_range(0, 17'h1FFFF));
            default: rt[k] = 17'h1FFFF;
          endcase
        end
        if ($urandom_range(0, 299) == 0) do_reset();
        step($urandom_range(0, 2) == 0, g, 18'($urandom), rt[0], rt[1], rt[2], rt[3]);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
